quadrature_decoder: RTL and testbench
=====================================

// Module: quadrature_decoder
// PURPOSE
//  Decodes a two-phase quadrature pair (enc_a/enc_b) into up/down steps and a wrapping position count.
//  This is the receive-side counterpart of up_down_counter: it recovers direction (upordown) and count from the encoder.
//  Sits between the external encoder pins and any logic consuming count/direction; inputs are asynchronous to clk.
// PARAMETERS
//  CNT_W        4   width of count; wraps modulo 2**CNT_W
//  SYNC_STAGES  2   flip-flop synchronizer depth per input (>=2)
//  FILT_LEN     3   consecutive equal synchronized samples required to accept a new level (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high; clears all state immediately
//  enc_a      in   1      quadrature phase A, asynchronous
//  enc_b      in   1      quadrature phase B, asynchronous
//  clear      in   1      synchronous count clear
//  error_clr  in   1      synchronous clear of sticky error
//  count      out  CNT_W  position count
//  upordown   out  1      direction of last valid step: 1=up, 0=down
//  step       out  1      one-cycle pulse on each accepted valid step
//  error      out  1      sticky flag: illegal transition seen
// BEHAVIOUR
//  - Reset values: count=0, upordown=0, step=0, error=0, filters and decoder return to uninitialised.
//  - Input path per channel: SYNC_STAGES-FF synchronizer, then glitch filter.
//    The filter output changes only after FILT_LEN consecutive identical synchronized samples.
//  - Decoder state = filtered {a,b}. Gray order 00->01->11->10->00 is UP; the reverse order is DOWN.
//  - First filtered sample after reset: loads the state only; no step, no error.
//  - Valid step (one bit changes): count +/-1 modulo 2**CNT_W (15+1=0, 0-1=15).
//    upordown is updated, and step=1 for exactly one cycle.
//  - Illegal transition (both bits change in one filtered update): error<=1, count and upordown unchanged.
//    step stays 0, and the state resynchronises to the new value.
//  - No change: step=0, outputs hold.
//  - Latency, encoder edge to count/step update: SYNC_STAGES+FILT_LEN+1 clk edges (6 at defaults).
//  - clear=1: count<=0 next edge. If clear and a valid step coincide, clear wins:
//    count=0, step=0, upordown still updated, decoder state still advances.
//  - error_clr=1 clears error unless an illegal transition occurs in the same cycle; set wins.
//  - Reset mid-sequence: outputs zero asynchronously. After release, the decoder re-initialises from the first filtered sample.
//  - Minimum resolvable phase dwell: FILT_LEN+1 cycles. Faster inputs may be filtered out or flagged illegal, never miscounted silently.
// STRUCTURE
//  - Shared header qd_defs.vh: Gray state constants QD_S00/QD_S01/QD_S11/QD_S10, DIR_UP=1'b1, DIR_DN=1'b0.
//  - Sub-module qd_input_filter (params SYNC_STAGES, FILT_LEN; ports clk, reset, din, dout, valid).
//    Instantiated once for A and once for B.
//  - Top level holds the decoder state register, init flag, transition classifier (case on {prev,cur}), count/error registers.
// TESTING
//  1. reset=1 for 50ns while toggling A/B -> count=0, step=0, error=0, upordown=0 throughout.
//  2. 20 up steps (A leads B, 8 cycles per phase) from 0 -> 20 step pulses, count 1..15,0,1..4.
//     Final count=4, upordown=1; each update lands 6 edges after its input edge.
//  3. From count=0, 3 down steps -> count 15,14,13; upordown=0; error=0.
//  4. 2-cycle glitch on enc_a while idle -> no step, count unchanged, error=0.
//  5. Force 00->11 held 8 cycles -> error=1, count unchanged, step=0.
//     Then pulse error_clr -> error=0; next valid step counts normally.
//  6. Assert clear in the cycle a step is decoded -> count=0, step=0.
//     Assert async reset mid-run between clk edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/quadrature_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_decoder_pkg
// Description : Shared constants and types for the quadrature decoder: Gray
//               state encodings of the filtered {a,b} pair, direction codes
//               and the transition classification type.
// Revision    : 1.0 - initial release
// ============================================================================
package quadrature_decoder_pkg;

    // Gray-coded decoder states, {a,b}. Walking this list forwards is UP.
    localparam logic [1:0] QD_S00 = 2'b00;
    localparam logic [1:0] QD_S01 = 2'b01;
    localparam logic [1:0] QD_S11 = 2'b11;
    localparam logic [1:0] QD_S10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Result of comparing the previous and current filtered state.
    typedef enum logic [1:0] {
        TR_NONE    = 2'd0,
        TR_UP      = 2'd1,
        TR_DN      = 2'd2,
        TR_ILLEGAL = 2'd3
    } qd_trans_e;

endpackage
`default_nettype wire

// File: rtl/quadrature_decoder_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : qd_input_filter
// Description : One encoder channel input path: SYNC_STAGES flip-flop
//               synchronizer followed by a glitch filter. dout only moves to a
//               new level after FILT_LEN consecutive identical synchronized
//               samples. valid rises with the first accepted level after reset.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               din   - raw asynchronous channel input
//               dout  - filtered level
//               valid - dout holds a real accepted level
// Revision    : 1.0 - initial release
// ============================================================================
module qd_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic valid
);

    localparam int c_RUN_W = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    // Tracks which synchronizer stages hold real samples rather than reset
    // values, so the filter never accepts the post-reset zeros as a level.
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_last;
    logic [c_RUN_W-1:0]     r_run;
    logic                   r_dout;
    logic                   r_valid;

    logic                   w_sample;
    logic                   w_sample_ok;
    logic [c_RUN_W-1:0]     w_run_next;

    assign w_sample    = r_sync[SYNC_STAGES-1];
    assign w_sample_ok = r_fill[SYNC_STAGES-1];

    // Run length of identical samples, saturating at FILT_LEN. A zero run
    // means no sample has been taken yet, so the first one starts a run.
    always_comb begin
        w_run_next = r_run;
        if (w_sample_ok) begin
            if ((r_run != '0) && (w_sample == r_last)) begin
                if (r_run != c_RUN_W'(FILT_LEN)) begin
                    w_run_next = r_run + c_RUN_W'(1);
                end
            end else begin
                w_run_next = c_RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_last  <= 1'b0;
            r_run   <= '0;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (w_sample_ok) begin
                r_last <= w_sample;
                r_run  <= w_run_next;
                if (w_run_next == c_RUN_W'(FILT_LEN)) begin
                    r_dout  <= w_sample;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quadrature_decoder
// Description : Decodes a two-phase quadrature pair into up/down steps and a
//               wrapping position count. Each channel is synchronized and
//               glitch filtered; the filtered {a,b} pair is tracked as a Gray
//               state and every change is classified as up, down or illegal.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-high reset
//               enc_a     - quadrature phase A (asynchronous)
//               enc_b     - quadrature phase B (asynchronous)
//               clear     - synchronous count clear
//               error_clr - synchronous clear of the sticky error flag
//               count     - position count, wraps modulo 2**CNT_W
//               upordown  - direction of last valid step (1 = up)
//               step      - one-cycle pulse per accepted valid step
//               error     - sticky illegal-transition flag
// Revision    : 1.0 - initial release
// ============================================================================
module quadrature_decoder
    import quadrature_decoder_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    input  logic             error_clr,
    output logic [CNT_W-1:0] count,
    output logic             upordown,
    output logic             step,
    output logic             error
);

    logic             w_a;
    logic             w_b;
    logic             w_a_valid;
    logic             w_b_valid;
    logic [1:0]       w_cur;
    qd_trans_e        w_trans;

    logic [1:0]       r_state;
    logic             r_init;
    logic [CNT_W-1:0] r_count;
    logic             r_dir;
    logic             r_step;
    logic             r_error;

    qd_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .din   (enc_a),
        .dout  (w_a),
        .valid (w_a_valid)
    );

    qd_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .din   (enc_b),
        .dout  (w_b),
        .valid (w_b_valid)
    );

    assign w_cur = {w_a, w_b};

    // Transition classifier. Nothing is classified until the state register
    // has been loaded from the first filtered sample after reset.
    always_comb begin
        w_trans = TR_NONE;
        if (r_init) begin
            case ({r_state, w_cur})
                {QD_S00, QD_S01},
                {QD_S01, QD_S11},
                {QD_S11, QD_S10},
                {QD_S10, QD_S00}: w_trans = TR_UP;
                {QD_S01, QD_S00},
                {QD_S11, QD_S01},
                {QD_S10, QD_S11},
                {QD_S00, QD_S10}: w_trans = TR_DN;
                {QD_S00, QD_S00},
                {QD_S01, QD_S01},
                {QD_S11, QD_S11},
                {QD_S10, QD_S10}: w_trans = TR_NONE;
                default:          w_trans = TR_ILLEGAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= QD_S00;
            r_init  <= 1'b0;
            r_count <= '0;
            r_dir   <= DIR_DN;
            r_step  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_step <= 1'b0;

            if (!r_init && w_a_valid && w_b_valid) begin
                r_state <= w_cur;
                r_init  <= 1'b1;
            end

            if ((w_trans == TR_UP) || (w_trans == TR_DN)) begin
                r_state <= w_cur;
                r_dir   <= (w_trans == TR_UP) ? DIR_UP : DIR_DN;
                // A coincident clear suppresses the count change and the pulse
                // but direction and state still follow the encoder.
                if (!clear) begin
                    r_step  <= 1'b1;
                    r_count <= (w_trans == TR_UP) ? (r_count + CNT_W'(1))
                                                  : (r_count - CNT_W'(1));
                end
            end else if (w_trans == TR_ILLEGAL) begin
                // Resynchronise to the new value so only one error is raised.
                r_state <= w_cur;
            end

            if (clear) begin
                r_count <= '0;
            end

            if (w_trans == TR_ILLEGAL) begin
                r_error <= 1'b1;
            end else if (error_clr) begin
                r_error <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign upordown = r_dir;
    assign step     = r_step;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quadrature_decoder
// Description : Directed self-checking bench for quadrature_decoder at default
//               parameters (CNT_W=4, SYNC_STAGES=2, FILT_LEN=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;

    logic       clk;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       clear;
    logic       error_clr;
    logic [3:0] count;
    logic       upordown;
    logic       step;
    logic       error;

    int n_cmp;
    int n_fail;

    quadrature_decoder #(
        .CNT_W       (4),
        .SYNC_STAGES (2),
        .FILT_LEN    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .clear     (clear),
        .error_clr (error_clr),
        .count     (count),
        .upordown  (upordown),
        .step      (step),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enc(input logic [1:0] ab);
        {enc_a, enc_b} = ab;
    endtask

    // One encoder phase, 8 cycles long. The update must land on exactly the
    // 6th edge after the input change and the step pulse must last one cycle.
    task automatic do_step(input logic [1:0] ab, input logic [3:0] ecnt,
                           input logic edir, input logic eerr, input string tag);
        set_enc(ab);
        repeat (5) tick();
        check({tag, " step_early"}, 32'(step), 32'd0);
        tick();
        check({tag, " step"}, 32'(step), 32'd1);
        check({tag, " count"}, 32'(count), 32'(ecnt));
        check({tag, " upordown"}, 32'(upordown), 32'(edir));
        check({tag, " error"}, 32'(error), 32'(eerr));
        tick();
        check({tag, " step_width"}, 32'(step), 32'd0);
        tick();
    endtask

    logic [1:0] up_seq [4];
    logic       saw_step;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        up_seq[0] = 2'b01;
        up_seq[1] = 2'b11;
        up_seq[2] = 2'b10;
        up_seq[3] = 2'b00;
        reset     = 1'b1;
        enc_a     = 1'b0;
        enc_b     = 1'b0;
        clear     = 1'b0;
        error_clr = 1'b0;

        // 1. Held in reset for 50ns while the inputs toggle.
        for (int i = 0; i < 5; i++) begin
            enc_a = ~enc_a;
            if (i[0]) enc_b = ~enc_b;
            tick();
            check("rst count", 32'(count), 32'd0);
            check("rst step", 32'(step), 32'd0);
            check("rst error", 32'(error), 32'd0);
            check("rst upordown", 32'(upordown), 32'd0);
        end
        set_enc(2'b00);
        tick();
        reset = 1'b0;
        saw_step = 1'b0;
        repeat (10) begin
            tick();
            saw_step |= step;
        end
        check("init no step", 32'(saw_step), 32'd0);
        check("init count", 32'(count), 32'd0);
        check("init error", 32'(error), 32'd0);

        // 2. Twenty up steps from 0; count wraps 15 -> 0 on the way to 4.
        for (int i = 1; i <= 20; i++) begin
            do_step(up_seq[(i - 1) % 4], 4'(i % 16), 1'b1, 1'b0, "up");
        end

        // 3. Clear to 0, then three down steps with wrap 0 -> 15.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear count", 32'(count), 32'd0);
        do_step(2'b10, 4'd15, 1'b0, 1'b0, "dn1");
        do_step(2'b11, 4'd14, 1'b0, 1'b0, "dn2");
        do_step(2'b01, 4'd13, 1'b0, 1'b0, "dn3");

        // 4. Two-cycle glitch on A is shorter than the filter length.
        enc_a = 1'b1;
        tick();
        tick();
        enc_a = 1'b0;
        saw_step = 1'b0;
        repeat (10) begin
            tick();
            saw_step |= step;
        end
        check("glitch no step", 32'(saw_step), 32'd0);
        check("glitch count", 32'(count), 32'd13);
        check("glitch error", 32'(error), 32'd0);

        // 5. Illegal 00 -> 11, sticky error, error_clr, then normal counting.
        do_step(2'b00, 4'd12, 1'b0, 1'b0, "pre_ill");
        set_enc(2'b11);
        repeat (5) tick();
        check("ill error_early", 32'(error), 32'd0);
        tick();
        check("ill error", 32'(error), 32'd1);
        check("ill step", 32'(step), 32'd0);
        check("ill count", 32'(count), 32'd12);
        check("ill upordown", 32'(upordown), 32'd0);
        repeat (2) tick();
        check("ill sticky", 32'(error), 32'd1);
        error_clr = 1'b1;
        tick();
        error_clr = 1'b0;
        check("error_clr", 32'(error), 32'd0);
        do_step(2'b10, 4'd13, 1'b1, 1'b0, "post_ill");

        // 6a. Clear coincides with a decoded down step (10 -> 11).
        set_enc(2'b11);
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr+step count", 32'(count), 32'd0);
        check("clr+step step", 32'(step), 32'd0);
        check("clr+step upordown", 32'(upordown), 32'd0);
        repeat (2) tick();
        // State advanced to 11, so 11 -> 01 is a down step: 0 - 1 = 15.
        do_step(2'b01, 4'd15, 1'b0, 1'b0, "wrap_dn");
        do_step(2'b11, 4'd0, 1'b1, 1'b0, "wrap_up");

        // Illegal 11 -> 00 to set error before the reset test.
        set_enc(2'b00);
        repeat (6) tick();
        check("ill2 error", 32'(error), 32'd1);
        check("ill2 count", 32'(count), 32'd0);
        repeat (2) tick();
        do_step(2'b01, 4'd1, 1'b1, 1'b1, "pre_rst");

        // 6b. Asynchronous reset between clock edges.
        #3;
        reset = 1'b1;
        #1;
        check("async count", 32'(count), 32'd0);
        check("async upordown", 32'(upordown), 32'd0);
        check("async error", 32'(error), 32'd0);
        check("async step", 32'(step), 32'd0);
        tick();
        reset = 1'b0;
        saw_step = 1'b0;
        repeat (12) begin
            tick();
            saw_step |= step;
        end
        check("reinit no step", 32'(saw_step), 32'd0);
        check("reinit count", 32'(count), 32'd0);
        check("reinit error", 32'(error), 32'd0);
        // Decoder reloaded 01 from the first filtered sample; 01 -> 11 is up.
        do_step(2'b11, 4'd1, 1'b1, 1'b0, "reinit_up");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
